// File: rtl/pzcorebus_response_switch_arbiter_if.sv
// Response-switch arbitration bundle: requester valids/masks and ack in,
// binary select, one-hot grant and lock indication out.
interface pzcorebus_response_switch_arbiter_if #(
    parameter int SLAVES       = 2,
    parameter int SELECT_WIDTH = $clog2(SLAVES)
);
    logic [SLAVES-1:0]       i_response_valid;
    logic [SLAVES-1:0]       i_mask;
    logic                    i_response_ack;
    logic [SELECT_WIDTH-1:0] o_select;
    logic [SLAVES-1:0]       o_grant;
    logic                    o_locked;

    modport master (
        output i_response_valid,
        output i_mask,
        output i_response_ack,
        input  o_select,
        input  o_grant,
        input  o_locked
    );

    modport slave (
        input  i_response_valid,
        input  i_mask,
        input  i_response_ack,
        output o_select,
        output o_grant,
        output o_locked
    );
endinterface

// File: rtl/pzcorebus_response_switch_arbiter.sv
// Round-robin arbiter for the response switch: zero-latency grant in IDLE,
// holds the owner locked until its last beat is acknowledged.
module pzcorebus_response_switch_arbiter #(
    parameter int SLAVES       = 2,
    parameter int SELECT_WIDTH = $clog2(SLAVES)
) (
    input logic i_clk,
    input logic i_rst,
    pzcorebus_response_switch_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam logic [SELECT_WIDTH-1:0] LAST = SELECT_WIDTH'(SLAVES - 1);

    state_t                  r_state;
    state_t                  w_state_n;
    logic [SELECT_WIDTH-1:0] r_owner;
    logic [SELECT_WIDTH-1:0] w_owner_n;
    logic [SELECT_WIDTH-1:0] r_ptr;
    logic [SELECT_WIDTH-1:0] w_ptr_n;
    logic [SLAVES-1:0]       w_eligible;
    logic [SELECT_WIDTH-1:0] w_scan;
    logic [SELECT_WIDTH-1:0] w_winner;
    logic                    w_found;

    // Explicit wrap keeps non-power-of-two builds inside 0..SLAVES-1
    function automatic logic [SELECT_WIDTH-1:0] f_next(
        input logic [SELECT_WIDTH-1:0] x
    );
        return (x == LAST) ? '0 : x + 1'b1;
    endfunction

    assign w_eligible = bus.i_response_valid & bus.i_mask;

    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_scan   = r_ptr;
        for (int i = 0; i < SLAVES; i++) begin
            if (!w_found && w_eligible[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
            w_scan = f_next(w_scan);
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_owner_n = r_owner;
        w_ptr_n   = r_ptr;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_owner_n = w_winner;
                    if (bus.i_response_ack) begin
                        w_ptr_n = f_next(w_winner);
                    end else begin
                        w_state_n = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (bus.i_response_ack) begin
                    w_state_n = IDLE;
                    w_ptr_n   = f_next(r_owner);
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_n;
            r_owner <= w_owner_n;
            r_ptr   <= w_ptr_n;
        end
    end

    // Outputs are forced quiet during reset regardless of stored state
    always_comb begin
        bus.o_select = '0;
        bus.o_grant  = '0;
        bus.o_locked = 1'b0;
        if (!i_rst) begin
            if (r_state == LOCKED) begin
                bus.o_select         = r_owner;
                bus.o_grant[r_owner] = 1'b1;
                bus.o_locked         = 1'b1;
            end else if (w_found) begin
                bus.o_select          = w_winner;
                bus.o_grant[w_winner] = 1'b1;
            end else begin
                bus.o_select = r_owner;
            end
        end
    end
endmodule

// File: tb/tb_pzcorebus_response_switch_arbiter.sv
// Bench for the response switch arbiter: 4- and 3-requester builds driven
// side by side and compared against a behavioural round-robin model.
module tb_pzcorebus_response_switch_arbiter;
    logic i_clk;
    logic i_rst;

    int checks = 0;
    int errors = 0;

    pzcorebus_response_switch_arbiter_if #(.SLAVES(4)) b4 ();
    pzcorebus_response_switch_arbiter_if #(.SLAVES(3)) b3 ();

    pzcorebus_response_switch_arbiter #(.SLAVES(4)) dut4 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (b4.slave)
    );

    pzcorebus_response_switch_arbiter #(.SLAVES(3)) dut3 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (b3.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Model state, index 0 = 4-slave build, index 1 = 3-slave build
    int n[2] = '{4, 3};
    bit m_locked[2];
    int m_owner[2];
    int m_ptr[2];

    function automatic int find_winner(input int id, input int elig);
        for (int k = 0; k < n[id]; k++) begin
            int idx;
            idx = (m_ptr[id] + k) % n[id];
            if (elig[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic cmp(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input int id, input int elig, input bit r,
                               input int sel, input int gnt, input int lck);
        int es, eg, el, w;
        es = 0; eg = 0; el = 0;
        if (!r) begin
            if (m_locked[id]) begin
                es = m_owner[id]; eg = 1 << m_owner[id]; el = 1;
            end else begin
                w = find_winner(id, elig);
                if (w >= 0) begin
                    es = w; eg = 1 << w;
                end else begin
                    es = m_owner[id];
                end
            end
        end
        cmp($sformatf("d%0d select", n[id]), sel, es);
        cmp($sformatf("d%0d grant", n[id]), gnt, eg);
        cmp($sformatf("d%0d locked", n[id]), lck, el);
        if (sel >= n[id]) cmp($sformatf("d%0d select range", n[id]), sel, n[id] - 1);
    endtask

    task automatic update_model(input int id, input int elig, input bit a, input bit r);
        int w;
        if (r) begin
            m_locked[id] = 0; m_owner[id] = 0; m_ptr[id] = 0;
        end else if (m_locked[id]) begin
            if (a) begin
                m_locked[id] = 0;
                m_ptr[id] = (m_owner[id] + 1) % n[id];
            end
        end else begin
            w = find_winner(id, elig);
            if (w >= 0) begin
                m_owner[id] = w;
                if (a) m_ptr[id] = (w + 1) % n[id];
                else   m_locked[id] = 1;
            end
        end
    endtask

    // One clock cycle; e4/e3 are optional literal select expectations (-1 = none)
    task automatic step(input logic [3:0] v4, input logic [3:0] m4, input bit a4,
                        input logic [2:0] v3, input logic [2:0] m3, input bit a3,
                        input bit r, input int e4, input int e3);
        int el4, el3;
        i_rst = r;
        b4.i_response_valid = v4; b4.i_mask = m4; b4.i_response_ack = a4;
        b3.i_response_valid = v3; b3.i_mask = m3; b3.i_response_ack = a3;
        el4 = int'(v4 & m4);
        el3 = int'(v3 & m3);
        #1;
        check_model(0, el4, r, int'(b4.o_select), int'(b4.o_grant), int'(b4.o_locked));
        check_model(1, el3, r, int'(b3.o_select), int'(b3.o_grant), int'(b3.o_locked));
        if (e4 >= 0) cmp("d4 directed select", int'(b4.o_select), e4);
        if (e3 >= 0) cmp("d3 directed select", int'(b3.o_select), e3);
        @(posedge i_clk);
        update_model(0, el4, a4, r);
        update_model(1, el3, a3, r);
        #1;
    endtask

    initial begin
        m_locked = '{0, 0}; m_owner = '{0, 0}; m_ptr = '{0, 0};
        // Reset with noisy inputs
        step(4'b1111, 4'b1111, 0, 3'b111, 3'b111, 0, 1, 0, 0);
        step(4'b0110, 4'b1111, 1, 3'b101, 3'b111, 1, 1, 0, 0);
        // Alternating single-beat grants; 3-slave build cycles through 0,1,2,0
        step(4'b1010, 4'b1111, 1, 3'b111, 3'b111, 1, 0, 1, 0);
        step(4'b1010, 4'b1111, 1, 3'b111, 3'b111, 1, 0, 3, 1);
        step(4'b1010, 4'b1111, 1, 3'b111, 3'b111, 1, 0, 1, 2);
        step(4'b1010, 4'b1111, 1, 3'b111, 3'b111, 1, 0, 3, 0);
        // Move pointer to 2, then slave2 holds the switch
        step(4'b0010, 4'b1111, 1, 3'b000, 3'b111, 0, 0, 1, -1);
        step(4'b1111, 4'b1111, 0, 3'b000, 3'b111, 0, 0, 2, -1);
        step(4'b1111, 4'b1111, 0, 3'b000, 3'b111, 0, 0, 2, -1);
        step(4'b1111, 4'b1111, 0, 3'b000, 3'b111, 0, 0, 2, -1);
        step(4'b1111, 4'b1111, 1, 3'b000, 3'b111, 0, 0, 2, -1);
        // Slave3 completes and the pointer wraps to slave0
        step(4'b1111, 4'b1111, 1, 3'b000, 3'b111, 0, 0, 3, -1);
        step(4'b0001, 4'b1111, 1, 3'b000, 3'b111, 0, 0, 0, -1);
        // Lock slave1, then mask it off mid-burst
        step(4'b1111, 4'b1111, 0, 3'b000, 3'b111, 0, 0, 1, -1);
        step(4'b1111, 4'b1101, 0, 3'b000, 3'b111, 0, 0, 1, -1);
        step(4'b1111, 4'b1101, 0, 3'b000, 3'b111, 0, 0, 1, -1);
        step(4'b1111, 4'b1101, 1, 3'b000, 3'b111, 0, 0, 1, -1);
        step(4'b1111, 4'b1101, 1, 3'b000, 3'b111, 0, 0, 2, -1);
        step(4'b0010, 4'b1101, 1, 3'b000, 3'b111, 0, 0, 2, -1);
        // Reset while slave2 is locked
        step(4'b0100, 4'b1111, 0, 3'b000, 3'b111, 0, 0, 2, -1);
        step(4'b0100, 4'b1111, 0, 3'b000, 3'b111, 0, 0, 2, -1);
        step(4'b0100, 4'b1111, 0, 3'b000, 3'b111, 0, 1, 0, -1);
        step(4'b0100, 4'b1111, 0, 3'b000, 3'b111, 0, 1, 0, -1);
        step(4'b0100, 4'b1111, 0, 3'b000, 3'b111, 0, 0, 2, -1);
        step(4'b0100, 4'b1111, 0, 3'b000, 3'b111, 0, 0, 2, -1);
        step(4'b0000, 4'b1111, 1, 3'b000, 3'b111, 1, 0, 2, -1);
        // Ack while idle with nothing eligible is ignored
        step(4'b0000, 4'b1111, 1, 3'b000, 3'b111, 1, 0, 2, 0);
        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            step(4'($urandom), 4'($urandom | $urandom), bit'($urandom_range(0, 2) != 0),
                 3'($urandom), 3'($urandom | $urandom), bit'($urandom_range(0, 2) != 0),
                 bit'($urandom_range(0, 39) == 0), -1, -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pzcorebus_response_switch_arbiter.md
PZCOREBUS_RESPONSE_SWITCH_ARBITER -- requirements
Module: pzcorebus_response_switch_arbiter

Interface
REQ-001 SHALL have parameter SLAVES, default 2, number of response requesters (>=2).
REQ-002 SHALL have parameter SELECT_WIDTH, default $clog2(SLAVES), width of the binary select.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port i_response_valid, input, SLAVES, per-slave response valid at the switch mux input.
REQ-006 SHALL have port i_mask, input, SLAVES, per-slave arbitration enable (1 = eligible).
REQ-007 SHALL have port i_response_ack, input, 1, last-burst beat accepted by master (switch o_response_ack).
REQ-008 SHALL have port o_select, output, SELECT_WIDTH, binary slave index driving the switch i_select.
REQ-009 SHALL have port o_grant, output, SLAVES, one-hot grant (all-zero when nothing granted).
REQ-010 SHALL have port o_locked, output, 1, high while a multi-beat or stalled response owns the switch.

Function
REQ-011 SHALL implement two states: IDLE and LOCKED.
REQ-012 Eligible request vector SHALL be i_response_valid & i_mask.
REQ-013 Round-robin pointer ptr (SELECT_WIDTH bits) SHALL give highest priority to index ptr, then ptr+1, ..., wrapping at SLAVES-1 to 0.
REQ-014 In IDLE with any eligible request, winner SHALL be chosen combinationally in the same cycle: o_select = winner, o_grant = onehot(winner), zero-cycle arbitration latency.
REQ-015 In IDLE with no eligible request, o_grant SHALL be 0, o_select SHALL hold registered owner, state remains IDLE.
REQ-016 IDLE with winner and i_response_ack=1 (single-beat response completed) SHALL stay IDLE, owner<=winner, ptr<=(winner+1) mod SLAVES.
REQ-017 IDLE with winner and i_response_ack=0 SHALL go to LOCKED next cycle with owner<=winner; ptr unchanged.
REQ-018 In LOCKED, o_select SHALL equal owner, o_grant = onehot(owner), o_locked = 1, regardless of i_response_valid or i_mask.
REQ-019 Clearing i_mask[owner] while LOCKED SHALL NOT release the lock; mask affects only new arbitration.
REQ-020 In LOCKED with i_response_ack=1, next state SHALL be IDLE and ptr<=(owner+1) mod SLAVES; the new arbitration occurs combinationally in the following cycle (one idle-free cycle gap not permitted to be skipped: no same-cycle re-grant).
REQ-021 ptr increment SHALL wrap explicitly at SLAVES-1 (non-power-of-two SLAVES never yields index >= SLAVES).
REQ-022 o_locked SHALL be 0 in IDLE.
REQ-023 i_response_ack while IDLE with no eligible request SHALL be ignored (no state or ptr change).
REQ-024 o_select SHALL never exceed SLAVES-1.

Reset
REQ-025 While i_rst=1 at a clock edge: state<=IDLE, owner<=0, ptr<=0.
REQ-026 While i_rst=1, o_grant SHALL be 0, o_locked 0, o_select 0, irrespective of inputs.
REQ-027 Reset asserted in LOCKED SHALL abandon the burst; first cycle after deassert arbitrates from ptr=0.

Verification (SLAVES=4, i_mask=4'b1111 unless stated)
REQ-028 Reset, then valid=4'b1010, ack=1 each cycle -> grants slave1, slave3, slave1, slave3; o_locked stays 0.
REQ-029 Valid=4'b1111, slave2 wins with ack=0 for 3 cycles then ack=1 -> o_select=2, o_locked=1 for 3 cycles; next cycle IDLE, ptr=3, slave3 granted.
REQ-030 Owner slave3 completes (ptr wraps) with valid=4'b0001 -> ptr=0, slave0 granted next cycle.
REQ-031 LOCKED on slave1, i_mask drops to 4'b1101 -> o_select stays 1 until ack; afterwards slave1 not granted while masked.
REQ-032 i_rst=1 mid-LOCKED on slave2 -> outputs 0 during reset; after deassert with valid=4'b0100 -> slave2 granted from ptr=0, o_locked 0->1 if ack=0.
REQ-033 SLAVES=3 build, repeated single-beat acks from all slaves -> o_select cycles 0,1,2,0; never 3.
